// File: rtl/reg_rename_file_if.sv
// Decoder read/rename and ROB commit signals of the register rename file.
interface reg_rename_file_if #(
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
);
    logic                     rdy_in;
    logic [REG_ID_BIT-1:0]    rs1_id;
    logic [REG_ID_BIT-1:0]    rs2_id;
    logic [31:0]              rs1_value;
    logic [31:0]              rs2_value;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic [ROB_WIDTH_BIT-1:0] rs1_tag;
    logic [ROB_WIDTH_BIT-1:0] rs2_tag;
    logic                     rename_en;
    logic [REG_ID_BIT-1:0]    rename_rd;
    logic [ROB_WIDTH_BIT-1:0] rename_rob_id;
    logic                     write_en;
    logic [REG_ID_BIT-1:0]    reg_id;
    logic [ROB_WIDTH_BIT-1:0] rob_id;
    logic [31:0]              value_out;
    logic                     clear_all;

    modport master (
        output rdy_in, rs1_id, rs2_id, rename_en, rename_rd, rename_rob_id,
               write_en, reg_id, rob_id, value_out, clear_all,
        input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );

    modport slave (
        input  rdy_in, rs1_id, rs2_id, rename_en, rename_rd, rename_rob_id,
               write_en, reg_id, rob_id, value_out, clear_all,
        output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tag, commit-port
// write-back, same-cycle commit bypass on reads, and mispredict flush.
module reg_rename_file #(
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    reg_rename_file_if.slave   bus
);
    localparam int NREG = 2 ** REG_ID_BIT;

    typedef struct packed {
        logic [31:0]              value;
        logic                     busy;
        logic [ROB_WIDTH_BIT-1:0] tag;
    } rd_t;

    logic [31:0]              val_q [NREG];
    logic [31:0]              val_d [NREG];
    logic [NREG-1:0]          busy_q;
    logic [NREG-1:0]          busy_d;
    logic [ROB_WIDTH_BIT-1:0] tag_q [NREG];
    logic [ROB_WIDTH_BIT-1:0] tag_d [NREG];

    rd_t rd1;
    rd_t rd2;

    // A commit whose tag still owns the register is forwarded straight to the reader.
    function automatic rd_t rd_port(input logic [REG_ID_BIT-1:0] id);
        rd_t r;
        r.value = val_q[id];
        r.busy  = busy_q[id];
        r.tag   = tag_q[id];
        if (id == '0) begin
            r = '0;
        end else if (bus.write_en && bus.reg_id == id && busy_q[id] &&
                     tag_q[id] == bus.rob_id) begin
            r.value = bus.value_out;
            r.busy  = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        rd1 = rd_port(bus.rs1_id);
        rd2 = rd_port(bus.rs2_id);
    end

    assign bus.rs1_value = rd1.value;
    assign bus.rs1_busy  = rd1.busy;
    assign bus.rs1_tag   = rd1.tag;
    assign bus.rs2_value = rd2.value;
    assign bus.rs2_busy  = rd2.busy;
    assign bus.rs2_tag   = rd2.tag;

    // Rename is applied after commit so a same-cycle rename owns busy/tag.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (bus.rdy_in) begin
            if (bus.clear_all) begin
                busy_d = '0;
            end else begin
                if (bus.write_en && bus.reg_id != '0) begin
                    val_d[bus.reg_id] = bus.value_out;
                    if (tag_q[bus.reg_id] == bus.rob_id) begin
                        busy_d[bus.reg_id] = 1'b0;
                    end
                end
                if (bus.rename_en && bus.rename_rd != '0) begin
                    busy_d[bus.rename_rd] = 1'b1;
                    tag_d[bus.rename_rd]  = bus.rename_rob_id;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end
endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: expected read results are queued as
// stimulus is driven and compared when the read ports are sampled.
module tb_reg_rename_file;
    logic clk_in;
    logic rst_in;

    reg_rename_file_if #(.REG_ID_BIT(5), .ROB_WIDTH_BIT(4)) bus ();

    reg_rename_file #(.REG_ID_BIT(5), .ROB_WIDTH_BIT(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] val;
        logic        busy;
        logic [3:0]  tag;
        bit          chk_tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string name, input int port, input logic [31:0] v,
                             input logic b, input logic [3:0] t, input bit ct);
        exp_t e;
        e.name = name; e.port = port; e.val = v; e.busy = b; e.tag = t; e.chk_tag = ct;
        sb_q.push_back(e);
    endtask

    task automatic sample_check();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.port == 0) begin
                chk({e.name, ".val"},  bus.rs1_value, e.val);
                chk({e.name, ".busy"}, {31'd0, bus.rs1_busy}, {31'd0, e.busy});
                if (e.chk_tag) chk({e.name, ".tag"}, {28'd0, bus.rs1_tag}, {28'd0, e.tag});
            end else begin
                chk({e.name, ".val"},  bus.rs2_value, e.val);
                chk({e.name, ".busy"}, {31'd0, bus.rs2_busy}, {31'd0, e.busy});
                if (e.chk_tag) chk({e.name, ".tag"}, {28'd0, bus.rs2_tag}, {28'd0, e.tag});
            end
        end
    endtask

    task automatic set_idle();
        bus.rdy_in        = 1'b1;
        bus.rs1_id        = '0;
        bus.rs2_id        = '0;
        bus.rename_en     = 1'b0;
        bus.rename_rd     = '0;
        bus.rename_rob_id = '0;
        bus.write_en      = 1'b0;
        bus.reg_id        = '0;
        bus.rob_id        = '0;
        bus.value_out     = '0;
        bus.clear_all     = 1'b0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] rob);
        set_idle();
        bus.rename_en = 1'b1; bus.rename_rd = rd; bus.rename_rob_id = rob;
        @(negedge clk_in);
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] v);
        bus.write_en = 1'b1; bus.reg_id = rd; bus.rob_id = rob; bus.value_out = v;
    endtask

    initial begin
        rst_in = 1'b0;
        set_idle();
        bus.rs1_id = 5'd5;
        expect_rd("rst_x5", 0, 32'h0, 1'b0, 4'h0, 1'b1);
        expect_rd("rst_x0", 1, 32'h0, 1'b0, 4'h0, 1'b1);
        sample_check();
        @(negedge clk_in);
        rst_in = 1'b1;

        set_idle(); bus.rs1_id = 5'd5; bus.rs2_id = 5'd0;
        expect_rd("post_rst_x5", 0, 32'h0, 1'b0, 4'h0, 1'b1);
        expect_rd("post_rst_x0", 1, 32'h0, 1'b0, 4'h0, 1'b1);
        sample_check();
        set_commit(5'd5, 4'd0, 32'hDEADBEEF);
        sample_check();
        @(negedge clk_in);
        set_idle(); bus.rs1_id = 5'd5;
        expect_rd("commit_x5", 0, 32'hDEADBEEF, 1'b0, 4'h0, 1'b1);
        sample_check();

        do_rename(5'd3, 4'd7);
        set_idle(); bus.rs1_id = 5'd3;
        expect_rd("ren_x3_t7", 0, 32'h0, 1'b1, 4'd7, 1'b1);
        sample_check();
        bus.rs2_id = 5'd3;
        set_commit(5'd3, 4'd7, 32'h12);
        expect_rd("byp_x3_p1", 0, 32'h12, 1'b0, 4'd0, 1'b0);
        expect_rd("byp_x3_p2", 1, 32'h12, 1'b0, 4'd0, 1'b0);
        sample_check();
        @(negedge clk_in);
        set_idle(); bus.rs1_id = 5'd3;
        expect_rd("cmt_x3", 0, 32'h12, 1'b0, 4'd0, 1'b0);
        sample_check();

        do_rename(5'd3, 4'd2);
        do_rename(5'd3, 4'd9);
        set_idle(); bus.rs1_id = 5'd3;
        set_commit(5'd3, 4'd2, 32'h55);
        expect_rd("old_cmt_nobyp", 0, 32'h12, 1'b1, 4'd9, 1'b1);
        sample_check();
        @(negedge clk_in);
        set_idle(); bus.rs1_id = 5'd3;
        expect_rd("old_cmt_x3", 0, 32'h55, 1'b1, 4'd9, 1'b1);
        sample_check();

        set_idle(); bus.rs2_id = 5'd4;
        set_commit(5'd4, 4'd1, 32'hA);
        bus.rename_en = 1'b1; bus.rename_rd = 5'd4; bus.rename_rob_id = 4'd6;
        expect_rd("same_pre_x4", 1, 32'h0, 1'b0, 4'd0, 1'b1);
        sample_check();
        @(negedge clk_in);
        set_idle(); bus.rs2_id = 5'd4;
        expect_rd("same_x4", 1, 32'hA, 1'b1, 4'd6, 1'b1);
        sample_check();

        set_idle(); bus.rdy_in = 1'b0; bus.rs1_id = 5'd4;
        set_commit(5'd4, 4'd6, 32'hBB);
        expect_rd("byp_rdy_lo", 0, 32'hBB, 1'b0, 4'd0, 1'b0);
        sample_check();
        @(negedge clk_in);
        set_idle(); bus.rdy_in = 1'b0;
        set_commit(5'd8, 4'd3, 32'h77);
        bus.rename_en = 1'b1; bus.rename_rd = 5'd9; bus.rename_rob_id = 4'd3;
        @(negedge clk_in);
        set_idle(); bus.rs1_id = 5'd8; bus.rs2_id = 5'd9;
        expect_rd("rdy_lo_x8", 0, 32'h0, 1'b0, 4'd0, 1'b1);
        expect_rd("rdy_lo_x9", 1, 32'h0, 1'b0, 4'd0, 1'b1);
        sample_check();
        bus.rs1_id = 5'd4;
        expect_rd("rdy_lo_x4", 0, 32'hA, 1'b1, 4'd6, 1'b1);
        sample_check();

        do_rename(5'd1, 4'd1);
        do_rename(5'd2, 4'd2);
        do_rename(5'd31, 4'd15);
        set_idle(); bus.rs1_id = 5'd31; bus.rs2_id = 5'd2;
        expect_rd("ren_x31", 0, 32'h0, 1'b1, 4'd15, 1'b1);
        expect_rd("ren_x2",  1, 32'h0, 1'b1, 4'd2,  1'b1);
        sample_check();
        set_idle(); bus.clear_all = 1'b1;
        bus.rename_en = 1'b1; bus.rename_rd = 5'd7; bus.rename_rob_id = 4'd5;
        @(negedge clk_in);
        set_idle(); bus.rs1_id = 5'd1; bus.rs2_id = 5'd2;
        expect_rd("clr_x1", 0, 32'h0, 1'b0, 4'd0, 1'b0);
        expect_rd("clr_x2", 1, 32'h0, 1'b0, 4'd0, 1'b0);
        sample_check();
        bus.rs1_id = 5'd31; bus.rs2_id = 5'd7;
        expect_rd("clr_x31", 0, 32'h0, 1'b0, 4'd0, 1'b0);
        expect_rd("clr_x7",  1, 32'h0, 1'b0, 4'd0, 1'b0);
        sample_check();
        bus.rs1_id = 5'd4;
        expect_rd("clr_x4", 0, 32'hA, 1'b0, 4'd0, 1'b0);
        sample_check();

        do_rename(5'd0, 4'd3);
        set_idle(); bus.rs1_id = 5'd0;
        set_commit(5'd0, 4'd3, 32'hFF);
        expect_rd("x0_cmt_byp", 0, 32'h0, 1'b0, 4'd0, 1'b1);
        sample_check();
        @(negedge clk_in);
        set_idle(); bus.rs1_id = 5'd0;
        expect_rd("x0_after", 0, 32'h0, 1'b0, 4'd0, 1'b1);
        sample_check();

        do_rename(5'd6, 4'd8);
        set_idle(); bus.rs1_id = 5'd5; bus.rs2_id = 5'd6;
        expect_rd("pre_arst_x5", 0, 32'hDEADBEEF, 1'b0, 4'd0, 1'b1);
        expect_rd("pre_arst_x6", 1, 32'h0, 1'b1, 4'd8, 1'b1);
        sample_check();
        rst_in = 1'b0;
        expect_rd("arst_x5", 0, 32'h0, 1'b0, 4'd0, 1'b1);
        expect_rd("arst_x6", 1, 32'h0, 1'b0, 4'd0, 1'b1);
        sample_check();
        #1 rst_in = 1'b1;
        @(negedge clk_in);
        expect_rd("post_arst_x6", 1, 32'h0, 1'b0, 4'd0, 1'b1);
        sample_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
